// File: rtl/tetris_pkg.sv
// Shared types for the playfield logic: piece codes, spawn bitmaps and the
// preview queue state encoding.
package tetris_pkg;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        Z    = 3'd1,
        S    = 3'd2,
        I    = 3'd3,
        O    = 3'd4,
        T    = 3'd5,
        J    = 3'd6,
        L    = 3'd7
    } piece_t;

    // shape[row] is one bitmap row, MSB is the leftmost column.
    typedef logic [3:0][3:0] shape_t;

    typedef enum logic [1:0] {
        StFill,
        StReady,
        StIssue,
        StRefill
    } queue_state_t;

    localparam int unsigned MAX_DEPTH = 4;

endpackage

// File: rtl/piece_shape_rom.sv
// Combinational lookup of the spawn bitmap for a piece code; NONE gives an
// empty bitmap.
module piece_shape_rom
    import tetris_pkg::*;
(
    input  piece_t piece,
    output shape_t shape
);

    always_comb begin
        shape = '0;
        unique case (piece)
            NONE: shape = '0;
            Z: begin shape[0] = 4'b1100; shape[1] = 4'b0110; end
            S: begin shape[0] = 4'b0110; shape[1] = 4'b1100; end
            I: begin shape[1] = 4'b1111; end
            O: begin shape[0] = 4'b0110; shape[1] = 4'b0110; end
            T: begin shape[0] = 4'b0100; shape[1] = 4'b1110; end
            J: begin shape[0] = 4'b1000; shape[1] = 4'b1110; end
            L: begin shape[0] = 4'b0010; shape[1] = 4'b1110; end
            default: shape = '0;
        endcase
    end

endmodule

// File: rtl/piece_queue_ctrl.sv
// Spawn scheduler: preview queue fed by the piece generator, one piece issued
// per request. Define HOLD_PIECE_EN to build the one-slot hold with lockout.
module piece_queue_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         src_type,
    input  logic               spawn_req,
`ifdef HOLD_PIECE_EN
    input  logic               hold_req,
`endif
    output logic               ready,
    output logic               spawn_valid,
    output logic [2:0]         spawn_type,
    output shape_t             spawn_shape,
    output logic [DEPTH*3-1:0] preview_type,
    output logic [2:0]         hold_type,
    output logic               hold_lock
);

    localparam logic [2:0] PTR_LAST = 3'(DEPTH - 1);

    queue_state_t            state_q, state_d;
    logic [DEPTH-1:0][2:0]   queue_q, queue_d;
    logic [2:0]              wr_ptr_q, wr_ptr_d;
    logic [2:0]              active_q, active_d;
    logic [2:0]              hold_q, hold_d;
    logic                    lock_q, lock_d;
    logic [2:0]              issue_d;
    logic                    ready_q, valid_q;
    logic [2:0]              type_q;
    shape_t                  shape_q, rom_shape;
    logic                    src_ok, hold_ok, do_spawn, do_hold;

    assign src_ok = (src_type != 3'd0);
`ifdef HOLD_PIECE_EN
    assign hold_ok = hold_req && !lock_q;
`else
    assign hold_ok = 1'b0;
`endif
    // spawn_req has priority over a simultaneous hold_req
    assign do_spawn = (state_q == StReady) && spawn_req;
    assign do_hold  = (state_q == StReady) && !spawn_req && hold_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StFill;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:   if (src_ok && wr_ptr_q == PTR_LAST) state_d = StReady;
            StReady:  if (do_spawn || do_hold) state_d = StIssue;
            StIssue:  state_d = (queue_q[DEPTH-1] == 3'd0) ? StRefill : StReady;
            StRefill: if (src_ok) state_d = StReady;
            default:  state_d = StFill;
        endcase
    end

    always_comb begin
        queue_d  = queue_q;
        wr_ptr_d = wr_ptr_q;
        active_d = active_q;
        hold_d   = hold_q;
        lock_d   = lock_q;
        issue_d  = 3'd0;
        unique case (state_q)
            StFill: begin
                if (src_ok) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (wr_ptr_q == 3'(i)) queue_d[i] = src_type;
                    end
                    wr_ptr_d = wr_ptr_q + 3'd1;
                end
            end
            StReady: begin
                // Spawn, or hold into an empty slot: both take the head and shift.
                if (do_spawn || (do_hold && hold_q == 3'd0)) begin
                    issue_d  = queue_q[0];
                    active_d = queue_q[0];
                    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                        queue_d[i] = queue_q[i+1];
                    end
                    queue_d[DEPTH-1] = 3'd0;
                    if (do_spawn) begin
                        lock_d = 1'b0;
                    end else begin
                        hold_d = active_q;
                        lock_d = 1'b1;
                    end
                end else if (do_hold) begin
                    issue_d  = hold_q;
                    hold_d   = active_q;
                    active_d = hold_q;
                    lock_d   = 1'b1;
                end
            end
            StRefill: if (src_ok) queue_d[DEPTH-1] = src_type;
            default: ;
        endcase
    end

    piece_shape_rom u_rom (
        .piece (piece_t'(issue_d)),
        .shape (rom_shape)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            queue_q  <= '0;
            wr_ptr_q <= 3'd0;
            active_q <= 3'd0;
            hold_q   <= 3'd0;
            lock_q   <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            type_q   <= 3'd0;
            shape_q  <= '0;
        end else begin
            queue_q  <= queue_d;
            wr_ptr_q <= wr_ptr_d;
            active_q <= active_d;
            hold_q   <= hold_d;
            lock_q   <= lock_d;
            ready_q  <= (state_d == StReady);
            valid_q  <= (state_d == StIssue);
            type_q   <= issue_d;
            shape_q  <= rom_shape;
        end
    end

    assign ready        = ready_q;
    assign spawn_valid  = valid_q;
    assign spawn_type   = type_q;
    assign spawn_shape  = shape_q;
    assign preview_type = queue_q;
    assign hold_type    = hold_q;
    assign hold_lock    = lock_q;

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Randomised self-checking bench for piece_queue_ctrl against a queue-based
// model of the spawn/hold rules.
module tb_piece_queue_ctrl;
    import tetris_pkg::*;

    localparam int unsigned DEPTH = 3;
`ifdef HOLD_PIECE_EN
    localparam bit HAS_HOLD = 1'b1;
`else
    localparam bit HAS_HOLD = 1'b0;
`endif
    // Spawn bitmaps as {row3,row2,row1,row0}, indexed by piece code.
    localparam logic [15:0] SHAPES [8] = '{16'h0000, 16'h006C, 16'h00C6, 16'h00F0,
                                          16'h0066, 16'h00E4, 16'h00E8, 16'h00E2};

    logic               clk, rst;
    logic [2:0]         src_type;
    logic               spawn_req, hold_req;
    logic               ready, spawn_valid;
    logic [2:0]         spawn_type;
    shape_t             spawn_shape;
    logic [DEPTH*3-1:0] preview_type;
    logic [2:0]         hold_type;
    logic               hold_lock;

    int          n_checks = 0;
    int          n_errors = 0;
    int          model_q[$];
    logic [2:0]  m_active, m_hold;
    logic        m_lock;

    piece_queue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_type     (src_type),
        .spawn_req    (spawn_req),
`ifdef HOLD_PIECE_EN
        .hold_req     (hold_req),
`endif
        .ready        (ready),
        .spawn_valid  (spawn_valid),
        .spawn_type   (spawn_type),
        .spawn_shape  (spawn_shape),
        .preview_type (preview_type),
        .hold_type    (hold_type),
        .hold_lock    (hold_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DEPTH*3-1:0] pack_q();
        logic [DEPTH*3-1:0] v = '0;
        for (int i = 0; i < int'(DEPTH); i++)
            if (i < model_q.size()) v[i*3 +: 3] = 3'(model_q[i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_active = 3'd0;
        m_hold   = 3'd0;
        m_lock   = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; src_type = 3'd0; spawn_req = 1'b0; hold_req = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        apply_reset();
        outs = {ready, spawn_valid, spawn_type, 16'(spawn_shape), hold_type, hold_lock};
        n_checks++;
        if (outs !== 32'd0) begin
            n_errors++; $display("FAIL reset_outputs: got %0h expected 0", outs);
        end
        n_checks++;
        if (preview_type !== '0) begin
            n_errors++; $display("FAIL reset_preview: got %0h expected 0", preview_type);
        end
        rst = 1'b0;
    endtask

    // fixed=1 drives 3,5,1,7,... and expects ready exactly DEPTH edges after release.
    task automatic test_fill(input bit fixed);
        int seq [4] = '{3, 5, 1, 7};
        logic [2:0] s;
        int edges = 0;
        for (int i = 0; i < 60; i++) begin
            if (fixed) s = 3'(seq[i % 4]);
            else s = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            src_type = s;
            tick();
            edges++;
            if (s != 3'd0 && model_q.size() < int'(DEPTH)) model_q.push_back(int'(s));
            n_checks++;
            if (ready !== (model_q.size() == int'(DEPTH))) begin
                n_errors++;
                $display("FAIL fill_ready: cycle %0d got %b expected %b", edges, ready,
                         model_q.size() == int'(DEPTH));
            end
            n_checks++;
            if (preview_type !== pack_q()) begin
                n_errors++;
                $display("FAIL fill_preview: got %0h expected %0h", preview_type, pack_q());
            end
            if (model_q.size() == int'(DEPTH)) break;
        end
        n_checks++;
        if (ready !== 1'b1 || (fixed && edges != int'(DEPTH))) begin
            n_errors++;
            $display("FAIL fill_done: ready %b after %0d edges", ready, edges);
        end
        src_type = 3'd0;
    endtask

    // One request cycle, then ISSUE, then REFILL with `zeros` invalid samples
    // followed by fill_val (random when 0). Noise requests outside READY.
    task automatic test_request(input bit sp, input bit ho, input int zeros,
                                input logic [2:0] fill_val);
        logic [2:0] exp_type = 3'd0;
        logic [2:0] s;
        bit accepted = 1'b0;
        bit swap = 1'b0;
        spawn_req = sp; hold_req = ho; src_type = 3'($urandom_range(0, 7));
        tick();
        spawn_req = 1'b0; hold_req = 1'b0;
        if (sp) begin
            exp_type = 3'(model_q.pop_front()); m_active = exp_type; m_lock = 1'b0;
            accepted = 1'b1;
        end else if (ho && HAS_HOLD && !m_lock) begin
            if (m_hold == 3'd0) begin
                exp_type = 3'(model_q.pop_front()); m_hold = m_active;
            end else begin
                exp_type = m_hold; m_hold = m_active; swap = 1'b1;
            end
            m_active = exp_type; m_lock = 1'b1; accepted = 1'b1;
        end
        n_checks++;
        if (spawn_valid !== accepted || ready !== !accepted) begin
            n_errors++;
            $display("FAIL req_handshake: valid %b ready %b expected valid %b", spawn_valid,
                     ready, accepted);
        end
        n_checks++;
        if (spawn_type !== exp_type || 16'(spawn_shape) !== SHAPES[exp_type]) begin
            n_errors++;
            $display("FAIL req_piece: got type %0d shape %h expected type %0d shape %h",
                     spawn_type, 16'(spawn_shape), exp_type, SHAPES[exp_type]);
        end
        n_checks++;
        if (preview_type !== pack_q() || hold_type !== m_hold || hold_lock !== m_lock) begin
            n_errors++;
            $display("FAIL req_state: preview %0h hold %0d lock %b expected %0h %0d %b",
                     preview_type, hold_type, hold_lock, pack_q(), m_hold, m_lock);
        end
        if (!accepted) return;
        src_type = 3'($urandom_range(0, 7)); spawn_req = 1'($urandom_range(0, 1));
        hold_req = 1'($urandom_range(0, 1));
        tick();
        spawn_req = 1'b0; hold_req = 1'b0;
        n_checks++;
        if (spawn_valid !== 1'b0 || ready !== swap) begin
            n_errors++;
            $display("FAIL issue_exit: valid %b ready %b expected 0 %b", spawn_valid, ready, swap);
        end
        if (swap) return;
        for (int i = 0; i <= zeros; i++) begin
            if (i < zeros) s = 3'd0;
            else s = (fill_val != 3'd0) ? fill_val : 3'($urandom_range(1, 7));
            src_type = s; spawn_req = 1'($urandom_range(0, 1));
            hold_req = 1'($urandom_range(0, 1));
            tick();
            spawn_req = 1'b0; hold_req = 1'b0;
            if (s != 3'd0) model_q.push_back(int'(s));
            n_checks++;
            if (ready !== (s != 3'd0) || spawn_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL refill_ready: step %0d ready %b expected %b", i, ready, s != 3'd0);
            end
        end
        n_checks++;
        if (preview_type !== pack_q()) begin
            n_errors++;
            $display("FAIL refill_preview: got %0h expected %0h", preview_type, pack_q());
        end
        src_type = 3'd0;
    endtask

    task automatic test_idle();
        src_type = 3'($urandom_range(0, 7));
        tick();
        n_checks++;
        if (ready !== 1'b1 || spawn_valid !== 1'b0 || preview_type !== pack_q()) begin
            n_errors++;
            $display("FAIL idle: ready %b valid %b preview %0h expected 1 0 %0h", ready,
                     spawn_valid, preview_type, pack_q());
        end
    endtask

    task automatic test_random(input int n);
        int op;
        for (int k = 0; k < n; k++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: test_request(1'b1, 1'b0, int'($urandom_range(0, 3)), 3'd0);
                1: test_request(1'b0, 1'b1, int'($urandom_range(0, 3)), 3'd0);
                2: test_request(1'b1, 1'b1, int'($urandom_range(0, 3)), 3'd0);
                default: test_idle();
            endcase
        end
    endtask

    task automatic test_mid_reset();
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({ready, spawn_valid, spawn_type, 16'(spawn_shape), hold_type, hold_lock} !== '0
            || preview_type !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: valid %b type %0d preview %0h expected all 0",
                     spawn_valid, spawn_type, preview_type);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (spawn_valid !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset_pulse: got %b expected 0", spawn_valid);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill(1'b1);
        test_request(1'b1, 1'b0, 5, 3'd7);
`ifdef HOLD_PIECE_EN
        test_request(1'b0, 1'b1, 0, 3'd4);
        test_request(1'b0, 1'b1, 0, 3'd0);
        test_request(1'b1, 1'b0, 1, 3'd2);
        test_request(1'b0, 1'b1, 0, 3'd0);
        test_request(1'b1, 1'b1, 0, 3'd0);
`endif
        test_random(60);
        test_mid_reset();
        test_fill(1'b0);
        test_random(40);
        test_reset();
        test_fill(1'b0);
        test_random(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
